// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter state encoding and memory access sizes.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } arb_state_t;

    // Memory access sizes, shared with the CPU's memory-size output.
    localparam logic [1:0] MS_NONE = 2'b00;
    localparam logic [1:0] MS_BYTE = 2'b01;
    localparam logic [1:0] MS_HALF = 2'b10;
    localparam logic [1:0] MS_WORD = 2'b11;

    localparam int unsigned TIMER_WIDTH = 16;

    // A data access of size "none" never touches memory.
    function automatic logic is_local_access(input logic [1:0] size);
        return size == MS_NONE;
    endfunction

endpackage

// File: rtl/arb_timer.sv
// Bounded-wait counter: clears on grant, counts idle cycles, flags the limit.
module arb_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins over enable; holds otherwise.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Limit is never zero, so a freshly cleared counter never reports terminal count.
    assign tc = (count_q == limit);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// One outstanding access at a time; data has priority; unacknowledged accesses time out.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // Instruction fetch port
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_data,
    output logic        o_if_valid,
    // Data port
    input  logic        i_d_load,
    input  logic        i_d_write,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [1:0]  i_d_size,
    output logic [31:0] o_d_rdata,
    output logic        o_d_valid,
    // Memory port
    output logic        o_m_req,
    output logic        o_m_we,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_wdata,
    output logic [1:0]  o_m_size,
    input  logic        i_m_ack,
    input  logic [31:0] i_m_rdata,
    // CPU control
    output logic        o_stall,
    output logic        o_timeout
);

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_CNT = TIMER_WIDTH'(TIMEOUT);

    arb_state_t  state_q, state_d;

    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [1:0]  m_size_q, m_size_d;

    logic [31:0] if_data_q, if_data_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_valid_q, d_valid_d;
    logic        timeout_q, timeout_d;

    logic        timer_clr;
    logic        timer_en;
    logic        timer_tc;

    logic        d_pending;
    logic        if_pending;

    // A port whose valid is high this cycle is masked so it can drop its level request.
    assign d_pending  = (i_d_load | i_d_write) & ~d_valid_q;
    assign if_pending = i_if_req & ~if_valid_q;

    arb_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .clr   (timer_clr),
        .en    (timer_en),
        .limit (TIMEOUT_CNT),
        .tc    (timer_tc)
    );

    // Next-state, memory-port capture and completion pulses.
    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_size_d   = m_size_q;
        if_data_d  = if_data_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        timeout_d  = 1'b0;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_pending) begin
                    if (is_local_access(i_d_size)) begin
                        // Zero-size access completes without a memory cycle.
                        d_rdata_d = '0;
                        d_valid_d = 1'b1;
                    end else begin
                        state_d   = GRANT_D;
                        m_req_d   = 1'b1;
                        m_we_d    = i_d_write;  // store wins over load
                        m_addr_d  = i_d_addr;
                        m_wdata_d = i_d_wdata;
                        m_size_d  = i_d_size;
                        timer_clr = 1'b1;
                    end
                end else if (if_pending) begin
                    state_d   = GRANT_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_if_addr;
                    m_wdata_d = '0;
                    m_size_d  = MS_WORD;
                    timer_clr = 1'b1;
                end
            end

            GRANT_D: begin
                if (i_m_ack) begin
                    d_rdata_d = i_m_rdata;
                    d_valid_d = 1'b1;
                    m_req_d   = 1'b0;
                    state_d   = IDLE;
                end else if (timer_tc) begin
                    d_rdata_d = '0;
                    d_valid_d = 1'b1;
                    timeout_d = 1'b1;
                    m_req_d   = 1'b0;
                    state_d   = IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end

            GRANT_I: begin
                if (i_m_ack) begin
                    if_data_d  = i_m_rdata;
                    if_valid_d = 1'b1;
                    m_req_d    = 1'b0;
                    state_d    = IDLE;
                end else if (timer_tc) begin
                    if_data_d  = '0;
                    if_valid_d = 1'b1;
                    timeout_d  = 1'b1;
                    m_req_d    = 1'b0;
                    state_d    = IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs; reset abandons any access in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_size_q   <= MS_NONE;
            if_data_q  <= '0;
            if_valid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_valid_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_size_q   <= m_size_d;
            if_data_q  <= if_data_d;
            if_valid_q <= if_valid_d;
            d_rdata_q  <= d_rdata_d;
            d_valid_q  <= d_valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_m_req    = m_req_q;
    assign o_m_we     = m_we_q;
    assign o_m_addr   = m_addr_q;
    assign o_m_wdata  = m_wdata_q;
    assign o_m_size   = m_size_q;
    assign o_if_data  = if_data_q;
    assign o_if_valid = if_valid_q;
    assign o_d_rdata  = d_rdata_q;
    assign o_d_valid  = d_valid_q;
    assign o_timeout  = timeout_q;

    // Stall while any request is raised and its completion pulse is not present.
    assign o_stall = (i_if_req & ~if_valid_q) | ((i_d_load | i_d_write) & ~d_valid_q);

endmodule
